uart_ctrl: RTL and testbench

//  Serial UART controller directly downstream of the memory bridge's UART port.
//  - Buffers CPU store bytes in a TX FIFO and serialises them 8N1 on txd_o.
//  - Deserialises rxd_i into an RX FIFO.
//  - Returns DATA (0xbfd003f8) and STATUS (0xbfd003fc) read values to the bridge.

---
 rtl/uart_ctrl_pkg.sv | 29 ++
 rtl/uart_ctrl_sync_fifo.sv | 63 ++++++
 rtl/uart_ctrl.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_ctrl_pkg
// Purpose : Shared definitions for the UART controller slice. Holds the state
//           encoding used by both serial FSMs, the STATUS register bit
//           positions and a helper that derives the baud divisor.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package uart_ctrl_pkg;

  // Both the transmit and the receive FSM walk the same four phases of an
  // 8N1 frame, so they share one encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uartState_t;

  // Bit positions inside the STATUS read value.
  localparam int STATUS_TX_READY_BIT = 0;
  localparam int STATUS_RX_READY_BIT = 1;
  localparam int STATUS_WIDTH        = 2;

  // Clock cycles per serial bit; integer division truncates.
  function automatic int calcDiv(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_ctrl_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Purpose : Single-clock first-word-fall-through FIFO used for both the TX and
//           the RX byte buffers of uart_ctrl.
// Ports   : clk      core clock
//           rst      synchronous active-high reset, empties the FIFO
//           i_push   write request, honoured only when not full
//           i_data   write data
//           i_pop    read request, honoured only when not empty
//           o_head   oldest entry (valid while o_empty is low)
//           o_full   no free entry
//           o_empty  no stored entry
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // that differ only in the wrap bit mean full.
  assign o_empty  = (r_wrPtr == r_rdPtr);
  assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  // Each request is judged against the pre-edge state, so a push into a full
  // FIFO is dropped even if a pop happens in the same cycle, and vice versa.
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr[AW-1:0]];

  // Pointer registers; they wrap naturally through their full range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers gate access.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_ctrl.sv
// -----------------------------------------------------------------------------
// uart_ctrl
// Purpose : UART controller behind the memory bridge. Buffers CPU stores in a
//           TX FIFO and sends them 8N1 on txd_o, deserialises rxd_i into an RX
//           FIFO, and exposes DATA / STATUS read values.
// Ports   : clk, rst          core clock, synchronous active-high reset
//           uart_we_n_i       store strobe (active low, one cycle per store)
//           uart_re_n_i       load strobe (active low, one cycle per load)
//           uart_sel_i        0 = DATA, 1 = STATUS
//           uart_tx_data_i    store byte
//           uart_rx_data_o    RX FIFO head, 8'h00 when empty
//           uart_tx_ready_o   TX FIFO not full
//           uart_rx_ready_o   RX FIFO not empty
//           rx_overrun_o      sticky, a received byte was dropped
//           txd_o             serial output, idles high
//           rxd_i             serial input, asynchronous
// -----------------------------------------------------------------------------
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_we_n_i,
  input  logic       uart_re_n_i,
  input  logic       uart_sel_i,
  input  logic [7:0] uart_tx_data_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_tx_ready_o,
  output logic       uart_rx_ready_o,
  output logic       rx_overrun_o,
  output logic       txd_o,
  input  logic       rxd_i
);

  localparam int DIV = calcDiv(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  // Bus decode
  logic w_txWrite;
  logic w_dataRead;
  logic [STATUS_WIDTH-1:0] w_status;

  // FIFO interfaces
  logic [7:0] w_txHead;
  logic       w_txFull;
  logic       w_txEmpty;
  logic       w_txPop;
  logic [7:0] w_rxHead;
  logic       w_rxFull;
  logic       w_rxEmpty;
  logic       w_rxPush;

  // TX FSM
  uartState_t r_txState, w_txStateNext;
  logic [CW-1:0] r_txCnt, w_txCntNext;
  logic [2:0]    r_txBit, w_txBitNext;
  logic [7:0]    r_txShift, w_txShiftNext;
  logic          r_txd, w_txdNext;

  // RX FSM
  logic          r_rxSync1, r_rxSync2;
  uartState_t    r_rxState, w_rxStateNext;
  logic [CW-1:0] r_rxCnt, w_rxCntNext;
  logic [2:0]    r_rxBit, w_rxBitNext;
  logic [7:0]    r_rxShift, w_rxShiftNext;
  logic          r_rxWaitHigh, w_rxWaitHighNext;
  logic          r_overrun, w_overrunNext;

  assign w_txWrite  = !uart_we_n_i && !uart_sel_i;
  assign w_dataRead = !uart_re_n_i && !uart_sel_i;

  assign w_status[STATUS_TX_READY_BIT] = !w_txFull;
  assign w_status[STATUS_RX_READY_BIT] = !w_rxEmpty;

  assign uart_tx_ready_o = w_status[STATUS_TX_READY_BIT];
  assign uart_rx_ready_o = w_status[STATUS_RX_READY_BIT];
  assign uart_rx_data_o  = w_rxEmpty ? 8'h00 : w_rxHead;
  assign rx_overrun_o    = r_overrun;
  assign txd_o           = r_txd;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_txWrite),
    .i_data  (uart_tx_data_i),
    .i_pop   (w_txPop),
    .o_head  (w_txHead),
    .o_full  (w_txFull),
    .o_empty (w_txEmpty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rxFifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rxPush),
    .i_data  (r_rxShift),
    .i_pop   (w_dataRead),
    .o_head  (w_rxHead),
    .o_full  (w_rxFull),
    .o_empty (w_rxEmpty)
  );

  // Transmit next-state logic. txd is registered, so each branch sets the
  // level the line takes from the next edge on. Leaving STOP with a byte
  // waiting reloads the shifter and goes straight to START.
  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
    w_txdNext     = r_txd;
    w_txPop       = 1'b0;
    case (r_txState)
      ST_IDLE: begin
        w_txdNext = 1'b1;
        if (!w_txEmpty) begin
          w_txPop       = 1'b1;
          w_txShiftNext = w_txHead;
          w_txCntNext   = '0;
          w_txdNext     = 1'b0;
          w_txStateNext = ST_START;
        end
      end
      ST_START: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext   = '0;
          w_txBitNext   = 3'd0;
          w_txdNext     = r_txShift[0];
          w_txShiftNext = r_txShift >> 1;
          w_txStateNext = ST_DATA;
        end else begin
          w_txCntNext = r_txCnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext = '0;
          if (r_txBit == 3'd7) begin
            w_txdNext     = 1'b1;
            w_txStateNext = ST_STOP;
          end else begin
            w_txBitNext   = r_txBit + 1'b1;
            w_txdNext     = r_txShift[0];
            w_txShiftNext = r_txShift >> 1;
          end
        end else begin
          w_txCntNext = r_txCnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_txCnt == BIT_LAST) begin
          w_txCntNext = '0;
          if (!w_txEmpty) begin
            w_txPop       = 1'b1;
            w_txShiftNext = w_txHead;
            w_txdNext     = 1'b0;
            w_txStateNext = ST_START;
          end else begin
            w_txdNext     = 1'b1;
            w_txStateNext = ST_IDLE;
          end
        end else begin
          w_txCntNext = r_txCnt + 1'b1;
        end
      end
      default: begin
        w_txdNext     = 1'b1;
        w_txStateNext = ST_IDLE;
      end
    endcase
  end

  // Receive next-state logic. The start bit is re-checked half a bit in so
  // later samples land mid-bit; a low stop bit is a framing error and the
  // receiver refuses to re-arm until the line has been seen high again.
  always_comb begin
    w_rxStateNext    = r_rxState;
    w_rxCntNext      = r_rxCnt;
    w_rxBitNext      = r_rxBit;
    w_rxShiftNext    = r_rxShift;
    w_rxWaitHighNext = r_rxWaitHigh;
    w_rxPush         = 1'b0;
    case (r_rxState)
      ST_IDLE: begin
        if (r_rxWaitHigh) begin
          if (r_rxSync2) w_rxWaitHighNext = 1'b0;
        end else if (!r_rxSync2) begin
          w_rxCntNext   = '0;
          w_rxStateNext = ST_START;
        end
      end
      ST_START: begin
        if (r_rxCnt == HALF_LAST) begin
          w_rxCntNext = '0;
          w_rxBitNext = 3'd0;
          if (r_rxSync2) w_rxStateNext = ST_IDLE;
          else           w_rxStateNext = ST_DATA;
        end else begin
          w_rxCntNext = r_rxCnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {r_rxSync2, r_rxShift[7:1]};
          if (r_rxBit == 3'd7) w_rxStateNext = ST_STOP;
          else                 w_rxBitNext   = r_rxBit + 1'b1;
        end else begin
          w_rxCntNext = r_rxCnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_rxCnt == BIT_LAST) begin
          w_rxCntNext   = '0;
          w_rxStateNext = ST_IDLE;
          if (r_rxSync2) w_rxPush         = 1'b1;
          else           w_rxWaitHighNext = 1'b1;
        end else begin
          w_rxCntNext = r_rxCnt + 1'b1;
        end
      end
      default: begin
        w_rxStateNext = ST_IDLE;
      end
    endcase
  end

  // Overrun flag: a DATA read clears it, but a byte dropped in the same cycle
  // sets it again so the loss is never hidden.
  always_comb begin
    w_overrunNext = r_overrun;
    if (w_dataRead)           w_overrunNext = 1'b0;
    if (w_rxPush && w_rxFull) w_overrunNext = 1'b1;
  end

  // State registers for both FSMs, the input synchroniser and the overrun
  // flag. Reset drops any frame in flight and forces the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txState    <= ST_IDLE;
      r_txCnt      <= '0;
      r_txBit      <= 3'd0;
      r_txShift    <= 8'h00;
      r_txd        <= 1'b1;
      r_rxSync1    <= 1'b1;
      r_rxSync2    <= 1'b1;
      r_rxState    <= ST_IDLE;
      r_rxCnt      <= '0;
      r_rxBit      <= 3'd0;
      r_rxShift    <= 8'h00;
      r_rxWaitHigh <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_txState    <= w_txStateNext;
      r_txCnt      <= w_txCntNext;
      r_txBit      <= w_txBitNext;
      r_txShift    <= w_txShiftNext;
      r_txd        <= w_txdNext;
      r_rxSync1    <= rxd_i;
      r_rxSync2    <= r_rxSync1;
      r_rxState    <= w_rxStateNext;
      r_rxCnt      <= w_rxCntNext;
      r_rxBit      <= w_rxBitNext;
      r_rxShift    <= w_rxShiftNext;
      r_rxWaitHigh <= w_rxWaitHighNext;
      r_overrun    <= w_overrunNext;
    end
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_ctrl
// Purpose : Directed-plus-random bench for uart_ctrl at DIV = 16. A line-level
//           UART receiver model decodes txd, and byte queues hold what the
//           receive FIFO is expected to contain.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_ctrl;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int DIV      = 16;
  localparam int DEPTH    = 16;
  localparam int FRAME    = 10 * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       weN = 1'b1;
  logic       reN = 1'b1;
  logic       sel = 1'b0;
  logic [7:0] txData = 8'h00;
  logic [7:0] rxData;
  logic       txReady;
  logic       rxReady;
  logic       overrun;
  logic       txd;
  logic       rxd = 1'b1;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  typedef struct {
    logic [7:0] data;
    logic       framingOk;
    int         startCyc;
  } txFrame_t;

  txFrame_t   txGot[$];
  logic [7:0] txExp[$];
  logic [7:0] rxModel[$];
  logic       overrunModel = 1'b0;

  uart_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .TX_DEPTH (DEPTH),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk             (clock),
    .rst             (reset),
    .uart_we_n_i     (weN),
    .uart_re_n_i     (reN),
    .uart_sel_i      (sel),
    .uart_tx_data_i  (txData),
    .uart_rx_data_o  (rxData),
    .uart_tx_ready_o (txReady),
    .uart_rx_ready_o (rxReady),
    .rx_overrun_o    (overrun),
    .txd_o           (txd),
    .rxd_i           (rxd)
  );

  // Free-running clock and cycle stamp used to measure frame spacing.
  always #5 clock = ~clock;
  always @(posedge clock) cycleCount++;

  // Independent line decoder: finds each start bit, samples every bit at its
  // centre and queues the byte with its start time and framing status.
  logic [7:0] monByte;
  logic       monStartOk;
  int         monStart;
  always begin
    @(negedge clock);
    if (!reset && txd === 1'b0) begin
      monStart = cycleCount;
      repeat (DIV / 2) @(negedge clock);
      monStartOk = (txd === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clock);
        monByte[i] = txd;
      end
      repeat (DIV) @(negedge clock);
      txGot.push_back('{data: monByte, framingOk: monStartOk && (txd === 1'b1),
                        startCyc: monStart});
    end
  end

  // Global time limit so a stuck design can never hang the run.
  initial begin
    #(400_000);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one bus cycle starting at a negedge and returns on the next
  // negedge with both strobes released.
  task automatic applyStimulus(input logic we, input logic re, input logic s, input logic [7:0] d);
    weN    = we;
    reN    = re;
    sel    = s;
    txData = d;
    @(negedge clock);
    weN = 1'b1;
    reN = 1'b1;
    sel = 1'b0;
  endtask

  task automatic sendRxFrame(input logic [7:0] d, input logic stopBit, input int stopCycles);
    rxd = 1'b0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (DIV) @(negedge clock);
    end
    rxd = stopBit;
    repeat (stopCycles) @(negedge clock);
    rxd = 1'b1;
  endtask

  task automatic modelRxByte(input logic [7:0] d);
    if (rxModel.size() < DEPTH) rxModel.push_back(d);
    else                        overrunModel = 1'b1;
  endtask

  task automatic readAndCheck(input string tag);
    logic [7:0] exp;
    exp = (rxModel.size() > 0) ? rxModel.pop_front() : 8'h00;
    checkOutput(tag, rxData, exp);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic waitTxFrames(input int n, input int budget);
    int left;
    left = budget;
    while (txGot.size() < n && left > 0) begin
      @(negedge clock);
      left--;
    end
    checkOutput("txFrameCount", txGot.size(), n);
  endtask

  // Compares decoded frames with txExp; consecutive frames must be exactly
  // one frame length apart when back-to-back is expected.
  task automatic checkTxFrames(input string tag, input bit backToBack);
    int prevStart;
    int idx;
    prevStart = 0;
    idx = 0;
    while (txGot.size() > 0 && txExp.size() > 0) begin
      txFrame_t f;
      f = txGot.pop_front();
      checkOutput($sformatf("%s_data%0d", tag, idx), f.data, txExp.pop_front());
      checkOutput($sformatf("%s_frame%0d", tag, idx), f.framingOk, 1'b1);
      if (backToBack && idx > 0)
        checkOutput($sformatf("%s_gap%0d", tag, idx), f.startCyc - prevStart, FRAME);
      prevStart = f.startCyc;
      idx++;
    end
    checkOutput($sformatf("%s_leftover", tag), txGot.size() + txExp.size(), 0);
  endtask

  initial begin
    logic [7:0] t1Byte;
    logic [7:0] rnd;
    logic       expBit;
    logic       lineIdle;
    logic       found;
    int         occ;
    int         bitIdx;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clock);
    checkOutput("rst_txd", txd, 1'b1);
    checkOutput("rst_txReady", txReady, 1'b1);
    checkOutput("rst_rxReady", rxReady, 1'b0);
    checkOutput("rst_rxData", rxData, 8'h00);
    checkOutput("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    // A store addressed to STATUS must not reach the transmitter.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
    lineIdle = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (txd !== 1'b1) lineIdle = 1'b0;
    end
    checkOutput("statusWriteIgnored", lineIdle, 1'b1);

    // ---------------- test 1: exact 0x55 waveform ----------------
    t1Byte = 8'h55;
    applyStimulus(1'b0, 1'b1, 1'b0, t1Byte);
    checkOutput("t1_highAfterPush", txd, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clock);
      bitIdx = c / DIV;
      if (bitIdx == 0)      expBit = 1'b0;
      else if (bitIdx == 9) expBit = 1'b1;
      else                  expBit = t1Byte[bitIdx-1];
      checkOutput($sformatf("t1_txd_c%0d", c), txd, expBit);
    end
    @(negedge clock);
    checkOutput("t1_idleHigh", txd, 1'b1);
    txExp.push_back(t1Byte);
    waitTxFrames(1, 50);
    checkTxFrames("t1", 1'b0);

    // ---------------- test 2: fill TX FIFO while busy ----------------
    applyStimulus(1'b0, 1'b1, 1'b0, 8'hAA);
    txExp.push_back(8'hAA);
    repeat (20) @(negedge clock);
    occ = 0;
    for (int k = 0; k < 17; k++) begin
      rnd = 8'(k);
      applyStimulus(1'b0, 1'b1, 1'b0, rnd);
      if (occ < DEPTH) begin
        occ++;
        txExp.push_back(rnd);
      end
      checkOutput($sformatf("t2_txReady%0d", k), txReady, (occ < DEPTH) ? 1'b1 : 1'b0);
    end
    waitTxFrames(17, 18 * FRAME);
    checkTxFrames("t2", 1'b1);
    repeat (DIV) @(negedge clock);

    // ---------------- test 3: receive 0xA3 ----------------
    sendRxFrame(8'hA3, 1'b1, DIV / 2);
    modelRxByte(8'hA3);
    found = 1'b0;
    for (int w = 0; w < 4 && !found; w++) begin
      @(negedge clock);
      if (rxReady === 1'b1) found = 1'b1;
    end
    checkOutput("t3_rxReadyInTime", found, 1'b1);
    checkOutput("t3_rxData", rxData, 8'hA3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("t3_statusReadNoPop", rxReady, 1'b1);
    readAndCheck("t3_read");
    checkOutput("t3_rxReadyCleared", rxReady, 1'b0);
    checkOutput("t3_rxDataEmpty", rxData, 8'h00);
    repeat (DIV) @(negedge clock);

    // ---------------- test 4: overrun ----------------
    for (int k = 0; k < 17; k++) begin
      rnd = 8'($urandom_range(0, 255));
      sendRxFrame(rnd, 1'b1, DIV);
      modelRxByte(rnd);
    end
    repeat (4) @(negedge clock);
    checkOutput("t4_overrun", overrun, overrunModel);
    checkOutput("t4_rxReady", rxReady, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      readAndCheck($sformatf("t4_read%0d", k));
      if (k == 0) checkOutput("t4_overrunCleared", overrun, 1'b0);
    end
    overrunModel = 1'b0;
    checkOutput("t4_drained", rxReady, 1'b0);

    // ---------------- test 5: glitch and framing error ----------------
    rxd = 1'b0;
    repeat (4) @(negedge clock);
    rxd = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("t5_glitchNoPush", rxReady, 1'b0);
    sendRxFrame(8'($urandom_range(0, 255)), 1'b0, DIV);
    repeat (20) @(negedge clock);
    checkOutput("t5_framingNoPush", rxReady, 1'b0);
    sendRxFrame(8'h3C, 1'b1, DIV);
    modelRxByte(8'h3C);
    repeat (4) @(negedge clock);
    checkOutput("t5_validAfter", rxReady, 1'b1);
    readAndCheck("t5_read3C");

    // ---------------- test 6: reset mid-frame ----------------
    rnd = 8'($urandom_range(0, 255));
    sendRxFrame(rnd, 1'b1, DIV);
    repeat (4) @(negedge clock);
    checkOutput("t6_preRxReady", rxReady, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    repeat (40) @(negedge clock);
    rxd = 1'b0;
    repeat (40) @(negedge clock);
    reset = 1'b1;
    rxd   = 1'b1;
    @(negedge clock);
    checkOutput("t6_rst_txd", txd, 1'b1);
    checkOutput("t6_rst_txReady", txReady, 1'b1);
    checkOutput("t6_rst_rxReady", rxReady, 1'b0);
    checkOutput("t6_rst_rxData", rxData, 8'h00);
    checkOutput("t6_rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    rxModel.delete();
    repeat (2 * FRAME) @(negedge clock);
    txGot.delete();
    txExp.delete();

    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom_range(0, 255));
      applyStimulus(1'b0, 1'b1, 1'b0, rnd);
      txExp.push_back(rnd);
    end
    waitTxFrames(3, 4 * FRAME);
    checkTxFrames("t6_tx", 1'b1);

    rnd = 8'($urandom_range(0, 255));
    sendRxFrame(rnd, 1'b1, DIV);
    modelRxByte(rnd);
    repeat (4) @(negedge clock);
    checkOutput("t6_rxReady", rxReady, 1'b1);
    readAndCheck("t6_rxRead");
    checkOutput("t6_rxEmpty", rxReady, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
